fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage plus IF/ID pipeline register. Holds PCF and issues requests to a variable-latency instruction memory, with at most one request outstanding. Delivers InstrD/PCD/PCPlus4D to Decode. Obeys the hazard unit's StallF, StallD and FlushD outputs and the Execute-stage redirect (PCSrcE/PCTargetE). Fills Decode with bubbles while memory is slow.

## Interface
- RESET_PC, 32'h0000_0000, PCF value after reset
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- StallF  in  1  hold PCF and fetch state (from hazard unit)
- StallD  in  1  hold IF/ID register (from hazard unit)
- FlushD  in  1  load bubble into IF/ID (from hazard unit)
- PCSrcE  in  1  taken branch/jump in Execute
- PCTargetE  in  32  redirect target
- ImemReq  out  1  request valid
- ImemAddr  out  32  request address, word aligned
- ImemReady  in  1  memory accepts request this cycle when ImemReq=1
- ImemRValid  in  1  response valid; never in the same cycle as acceptance
- ImemRData  in  32  response instruction
- InstrD  out  32  Decode instruction
- PCD  out  32  Decode PC
- PCPlus4D  out  32  PCD+4
- ValidD  out  1  InstrD is a real instruction

## Operation
- States: IDLE (nothing outstanding), WAIT (one request outstanding), DROP (outstanding response is wrong-path), BUF (response captured, Decode stalled).
- "Deliver" means StallF=0 and StallD=0 and FlushD=0 and PCSrcE=0.
- IDLE:
  - ImemReq = ~PCSrcE; ImemAddr = PCF.
  - If PCSrcE=1: PCF<=PCTargetE, stay IDLE.
  - Else if accepted: go to WAIT.
- WAIT, with ImemRValid=1:
  - If PCSrcE=1: discard the response; PCF<=PCTargetE; go to IDLE.
  - Else if deliver:
    - IF/ID <= {ImemRData, PCF, PCF+4, Valid=1}; PCF<=PCF+4.
    - Back-to-back issue in the same cycle: ImemReq=1, ImemAddr=PCF+4.
    - If accepted, stay WAIT; otherwise go to IDLE.
  - Else (stalled or flushed without redirect): capture ImemRData into the buffer; go to BUF.
- WAIT, with ImemRValid=0:
  - If PCSrcE=1: PCF<=PCTargetE; go to DROP.
- DROP:
  - ImemReq=0.
  - When ImemRValid=1: discard the data; go to IDLE.
  - PCSrcE in DROP updates PCF only.
- BUF:
  - ImemReq=0.
  - If PCSrcE=1: discard the buffer; PCF<=PCTargetE; go to IDLE.
  - Else if deliver: IF/ID <= {buffer, PCF, PCF+4, 1}; PCF<=PCF+4; go to IDLE.
- IF/ID update priority, per cycle:
  1. FlushD=1: load {NOP, 0, 0, Valid=0}.
  2. Else StallD=1: hold.
  3. Else a delivery occurs: load the instruction.
  4. Else: load the bubble.
- StallF=1 holds PCF and blocks new requests (ImemReq=0 in IDLE). It never masks an ImemRValid, which is always consumed into IF/ID or the buffer.
- PCSrcE=1 overrides StallF for the PCF update.
- Arithmetic: PC+4 is modulo 2^32 (0xFFFF_FFFC+4 = 0). ImemAddr[1:0] is always 0. PCTargetE[1:0] is forced to 0.

## Timing
- Reset values, asserted asynchronously:
  - PCF = RESET_PC; state = IDLE.
  - ImemReq = 0 while reset is high.
  - InstrD = NOP; PCD = 0; PCPlus4D = 0; ValidD = 0.
- ImemReq and ImemAddr are combinational from state, PCF, PCSrcE, StallF and ImemRValid. All other outputs are registered.
- Latency: a response in cycle N appears on InstrD/ValidD in cycle N+1.
- Throughput: with 1-cycle memory and no hazards, one instruction per cycle.
- Reset during WAIT or DROP: the in-flight response that arrives after reset deasserts must be discarded. Memory is reset by the same reset, so no response arrives after reset.
- FlushD and StallD together: flush wins.

## Test plan
- Reset then 1-cycle memory, RESET_PC=0x100, no hazards → ImemAddr 0x100, 0x104, 0x108 on consecutive cycles; ValidD=1 from the 3rd cycle with PCD 0x100, 0x104, 0x108 and PCPlus4D=PCD+4.
- 3-cycle memory latency → InstrD=NOP and ValidD=0 between instructions; each instruction appears exactly once.
- StallF=StallD=1 for 2 cycles while a response arrives → state BUF; IF/ID holds its prior value; the buffered instruction appears the cycle after the stall drops; PCF advances by exactly 4.
- PCSrcE=1, PCTargetE=0x200, while a request to 0x10C is in WAIT → the 0x10C response is dropped; the next request is to 0x200; no ValidD=1 with PCD=0x10C.
- FlushD=1 with StallD=1 → IF/ID = {NOP, 0, 0, 0}.
- Asynchronous reset pulse mid-WAIT → outputs reach their reset values without a clock edge; fetch resumes at RESET_PC.
- PCF=0xFFFF_FFFC delivered → PCPlus4D=0; next ImemAddr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register; one imem request outstanding at most.
// Latency: imem response in cycle N is visible on InstrD/ValidD in cycle N+1.
// Backpressure: StallF/StallD hold PCF and IF/ID; a response arriving under stall is parked in a one-entry buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  // IDLE: nothing outstanding; WAIT: one request in flight;
  // DROP: in-flight response belongs to a squashed path; BUF: response parked while Decode stalls.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    BUF  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] buf_q, buf_d;

  // IF/ID register
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        req;
  logic [31:0] addr;
  logic        deliver;
  logic [31:0] dlv_instr;
  logic        deliver_ok;
  logic [31:0] pcf_plus4;
  logic [31:0] target;

  // Wraps modulo 2^32; redirect targets are forced to word alignment.
  assign pcf_plus4  = pcf_q + 32'd4;
  assign target     = PCTargetE & 32'hFFFF_FFFC;
  assign deliver_ok = ~StallF & ~StallD & ~FlushD & ~PCSrcE;

  // Fetch FSM: next state, next PCF, buffer capture and request generation.
  always_comb begin
    state_d   = state_q;
    pcf_d     = pcf_q;
    buf_d     = buf_q;
    req       = 1'b0;
    addr      = pcf_q;
    deliver   = 1'b0;
    dlv_instr = ImemRData;
    unique case (state_q)
      IDLE: begin
        req = ~PCSrcE & ~StallF;
        if (PCSrcE) begin
          pcf_d = target;
        end else if (req && ImemReady) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ImemRValid) begin
          if (PCSrcE) begin
            // Response is wrong-path: drop it and restart at the target.
            pcf_d   = target;
            state_d = IDLE;
          end else if (deliver_ok) begin
            // Hand the response to Decode and issue the next fetch in the same cycle.
            deliver = 1'b1;
            pcf_d   = pcf_plus4;
            req     = 1'b1;
            addr    = pcf_plus4;
            state_d = ImemReady ? WAIT : IDLE;
          end else begin
            // Response cannot be refused, so park it until Decode frees up.
            buf_d   = ImemRData;
            state_d = BUF;
          end
        end else if (PCSrcE) begin
          pcf_d   = target;
          state_d = DROP;
        end
      end
      DROP: begin
        if (PCSrcE) begin
          pcf_d = target;
        end
        if (ImemRValid) begin
          state_d = IDLE;
        end
      end
      BUF: begin
        if (PCSrcE) begin
          pcf_d   = target;
          state_d = IDLE;
        end else if (deliver_ok) begin
          deliver   = 1'b1;
          dlv_instr = buf_q;
          pcf_d     = pcf_plus4;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fetch state, PCF and parked-response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pcf_q   <= RESET_PC;
      buf_q   <= NOP;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      buf_q   <= buf_d;
    end
  end

  // IF/ID next value: flush beats stall, stall beats delivery, otherwise a bubble.
  always_comb begin
    instr_d = NOP;
    pcd_d   = 32'd0;
    pcp4_d  = 32'd0;
    valid_d = 1'b0;
    if (FlushD) begin
      instr_d = NOP;
    end else if (StallD) begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
    end else if (deliver) begin
      instr_d = dlv_instr;
      pcd_d   = pcf_q;
      pcp4_d  = pcf_plus4;
      valid_d = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP;
      pcd_q   <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  // No request may escape while reset is held.
  assign ImemReq  = req & ~reset;
  assign ImemAddr = addr & 32'hFFFF_FFFC;

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady, ImemRValid;
  logic [31:0] ImemRData;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int total;
  int bad;

  // expected PCs of delivered instructions, in order
  logic [31:0] exp_q[$];

  // memory model state
  int          base_lat;
  int          slow_lat;
  logic [31:0] slow_addr;
  logic        acc, pend;
  logic [31:0] acc_addr, paddr;
  int          cnt;

  // monitor state
  logic        held;
  logic [31:0] last_instr, last_pc, last_pc4;
  logic        last_vld;
  logic [31:0] e_pc;

  fetch_unit #(.RESET_PC(32'h0000_0100), .NOP(NOP_I)) dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemReady (ImemReady),
    .ImemRValid(ImemRValid),
    .ImemRData (ImemRData),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Variable-latency memory: samples acceptance mid-cycle, answers lat cycles later.
  initial begin
    ImemRValid = 1'b0;
    ImemRData  = 32'd0;
    pend       = 1'b0;
    acc        = 1'b0;
    acc_addr   = 32'd0;
    paddr      = 32'd0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      acc      = ImemReq && ImemReady && !reset;
      acc_addr = ImemAddr;
      if (reset) pend = 1'b0;
      @(posedge clk);
      #1;
      ImemRValid = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (acc) begin
          pend  = 1'b1;
          paddr = acc_addr;
          cnt   = (acc_addr == slow_addr) ? slow_lat : base_lat;
        end
        if (pend) begin
          if (cnt <= 1) begin
            ImemRValid = 1'b1;
            ImemRData  = instr_of(paddr);
            pend       = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each new valid IF/ID, checks bubbles and held values.
  initial begin
    held       = 1'b0;
    last_instr = NOP_I;
    last_pc    = 32'd0;
    last_pc4   = 32'd0;
    last_vld   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_instr", InstrD, last_instr);
          chk("hold_pcd", PCD, last_pc);
          chk("hold_pcplus4", PCPlus4D, last_pc4);
          chk("hold_valid", 32'(ValidD), 32'(last_vld));
        end else if (ValidD) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_delivery: got pcd %h, expected none", PCD);
          end else begin
            e_pc = exp_q.pop_front();
            chk("deliv_instr", InstrD, instr_of(e_pc));
            chk("deliv_pcd", PCD, e_pc);
            chk("deliv_pcplus4", PCPlus4D, e_pc + 32'd4);
          end
        end else begin
          chk("bubble_instr", InstrD, NOP_I);
          chk("bubble_pcd", PCD, 32'd0);
          chk("bubble_pcplus4", PCPlus4D, 32'd0);
        end
        last_instr = InstrD;
        last_pc    = PCD;
        last_pc4   = PCPlus4D;
        last_vld   = ValidD;
        held       = StallD && !FlushD;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    total     = 0;
    bad       = 0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'd0;
    ImemReady = 1'b1;
    base_lat  = 1;
    slow_lat  = 3;
    slow_addr = 32'h0000_010C;
    reset     = 1'b0;
    #1 reset  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(ImemReq), 32'd0);
    chk("rst_instr", InstrD, NOP_I);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcplus4", PCPlus4D, 32'd0);
    chk("rst_valid", 32'(ValidD), 32'd0);

    // 1-cycle memory streaming, then redirect while 0x10C is outstanding
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    exp_q.push_back(32'h200);
    next_cycle(); reset = 1'b0;
    @(negedge clk); chk("c1_req", 32'(ImemReq), 32'd1); chk("c1_addr", ImemAddr, 32'h100);
    next_cycle();
    @(negedge clk); chk("c2_addr", ImemAddr, 32'h104);
    next_cycle();
    @(negedge clk); chk("c3_addr", ImemAddr, 32'h108);
    next_cycle();
    @(negedge clk); chk("c4_addr", ImemAddr, 32'h10C);
    next_cycle(); PCSrcE = 1'b1; PCTargetE = 32'h0000_0202;
    @(negedge clk); chk("redir_wait_req", 32'(ImemReq), 32'd0);
    next_cycle(); PCSrcE = 1'b0; PCTargetE = 32'd0;
    @(negedge clk); chk("drop_req", 32'(ImemReq), 32'd0);
    next_cycle();
    @(negedge clk); chk("drop_resp_req", 32'(ImemReq), 32'd0);
    next_cycle();
    @(negedge clk); chk("redir_req", 32'(ImemReq), 32'd1); chk("redir_addr", ImemAddr, 32'h200);
    next_cycle();
    next_cycle();
    @(negedge clk);
    // asynchronous reset while a request is in flight
    #2 reset = 1'b1;
    #1;
    chk("async_instr", InstrD, NOP_I);
    chk("async_pcd", PCD, 32'd0);
    chk("async_pcplus4", PCPlus4D, 32'd0);
    chk("async_valid", 32'(ValidD), 32'd0);
    chk("async_req", 32'(ImemReq), 32'd0);
    base_lat  = 3;
    slow_addr = 32'h0000_0001;
    repeat (2) next_cycle();

    // 3-cycle memory, then StallF/StallD over an arriving response
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C);
    next_cycle(); reset = 1'b0;
    @(negedge clk); chk("resume_req", 32'(ImemReq), 32'd1); chk("resume_addr", ImemAddr, 32'h100);
    repeat (11) next_cycle();
    next_cycle(); StallF = 1'b1; StallD = 1'b1;
    @(negedge clk); chk("stall_resp_req", 32'(ImemReq), 32'd0);
    next_cycle();
    @(negedge clk); chk("buf_req", 32'(ImemReq), 32'd0);
    next_cycle(); StallF = 1'b0; StallD = 1'b0;
    @(negedge clk); chk("buf_deliver_req", 32'(ImemReq), 32'd0);
    next_cycle(); StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
    @(negedge clk); chk("after_buf_addr", ImemAddr, 32'h110);
    next_cycle();
    @(negedge clk);
    chk("flush_instr", InstrD, NOP_I);
    chk("flush_pcd", PCD, 32'd0);
    chk("flush_pcplus4", PCPlus4D, 32'd0);
    chk("flush_valid", 32'(ValidD), 32'd0);
    chk("stallf_req", 32'(ImemReq), 32'd0);
    chk("stallf_addr", ImemAddr, 32'h110);
    next_cycle(); reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; base_lat = 1;
    repeat (2) next_cycle();

    // PC wrap at the top of the address space
    exp_q.push_back(32'hFFFF_FFFC);
    next_cycle(); reset = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
    @(negedge clk); chk("idle_redir_req", 32'(ImemReq), 32'd0);
    next_cycle(); PCSrcE = 1'b0; PCTargetE = 32'd0;
    @(negedge clk); chk("wrap_req", 32'(ImemReq), 32'd1); chk("wrap_addr", ImemAddr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk); chk("wrap_next_addr", ImemAddr, 32'd0); chk("wrap_next_req", 32'(ImemReq), 32'd1);
    next_cycle();
    @(negedge clk);
    #2 reset = 1'b1;
    next_cycle();
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
